tpg_source: RTL and testbench

//   Synthesizable traffic pattern generator feeding one NoC node. It injects
//   NUM_PKTS single-flit packets over a valid/ready stream, using the flit

---
 rtl/lynx_bfm_pkg.sv | 55 +++++
 rtl/tpg_source_dest_sel.sv | 35 +++
 rtl/tpg_source.sv | 129 ++++++++++++
 tb/tb_tpg_source.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_bfm_pkg.sv
// Flit layout shared by the traffic source and the node sink: src | dst | id | data counter.
// Field positions are derived from the flit width and the node address width.
package lynx_bfm_pkg;

  localparam int MAX_W = 64;
  localparam int ID_W  = 8;

  typedef logic [MAX_W-1:0] wide_flit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } tpg_state_t;

  function automatic int calc_dw(input int width, input int na);
    return width - 2 * na - ID_W;
  endfunction

  // LSB positions of each field
  function automatic int data_pos();
    return 0;
  endfunction

  function automatic int id_pos(input int width, input int na);
    return calc_dw(width, na);
  endfunction

  function automatic int dst_pos(input int width, input int na);
    return id_pos(width, na) + ID_W;
  endfunction

  function automatic int src_pos(input int width, input int na);
    return dst_pos(width, na) + na;
  endfunction

  function automatic wide_flit_t pack_flit(input int width, input int na,
                                           input logic [31:0] src,
                                           input logic [31:0] dst,
                                           input logic [ID_W-1:0] id,
                                           input wide_flit_t data);
    wide_flit_t m_na;
    wide_flit_t m_dw;
    wide_flit_t f;
    m_na = (wide_flit_t'(1) << na) - wide_flit_t'(1);
    m_dw = (wide_flit_t'(1) << calc_dw(width, na)) - wide_flit_t'(1);
    f = ((data & m_dw) << data_pos())
      | (wide_flit_t'(id) << id_pos(width, na))
      | ((wide_flit_t'(dst) & m_na) << dst_pos(width, na))
      | ((wide_flit_t'(src) & m_na) << src_pos(width, na));
    return f;
  endfunction

endpackage

// File: rtl/tpg_source_dest_sel.sv
// Round-robin destination register: walks all node indices in order, never selecting NODE.
module tpg_dest_sel #(
  parameter int N    = 16,
  parameter int NA   = 4,
  parameter int NODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_advance,
  input  logic          i_reload,
  output logic [NA-1:0] o_dest
);

  localparam int FIRST = (NODE + 1) % N;

  logic [NA-1:0] r_dest;

  function automatic logic [NA-1:0] step(input logic [NA-1:0] d);
    int n;
    n = (int'(d) + 1) % N;
    if (n == NODE) n = (n + 1) % N;
    return NA'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_reload) begin
      r_dest <= NA'(FIRST);
    end else if (i_advance) begin
      r_dest <= step(r_dest);
    end
  end

  assign o_dest = r_dest;

endmodule

// File: rtl/tpg_source.sv
// Traffic pattern generator: on start, injects NUM_PKTS single-flit packets over valid/ready,
// optionally spaced by GAP idle cycles, then holds done until the next start.
module tpg_source
  import lynx_bfm_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 0,
  parameter int DEST_MODE    = 0,
  parameter int DEST         = 15,
  parameter int NUM_PKTS     = 16,
  parameter int GAP          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             done,
  output logic [15:0]      sent_cnt
);

  localparam int NA     = N_ADDR_WIDTH;
  localparam int DW_RAW = calc_dw(WIDTH, NA);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;

  if (DW_RAW < 1) begin : g_bad_width
    $error("tpg_source: WIDTH too small for src/dst/id/data layout");
  end
  if (N < 2) begin : g_bad_n
    $error("tpg_source: N must be at least 2");
  end
  if (NUM_PKTS < 1) begin : g_bad_pkts
    $error("tpg_source: NUM_PKTS must be at least 1");
  end
  if (DEST_MODE == 0 && DEST == NODE) begin : g_bad_dest
    $error("tpg_source: fixed DEST must differ from NODE");
  end

  tpg_state_t     r_state;
  tpg_state_t     w_state_nxt;
  logic [7:0]     r_id;
  logic [DW-1:0]  r_data;
  logic [15:0]    r_sent;
  logic [GW-1:0]  r_gap;
  logic [NA-1:0]  w_dest;
  logic           w_accept;
  logic           w_run_start;
  logic           w_last;

  assign w_last = (r_sent == 16'(NUM_PKTS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run_start = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SEND;
          w_run_start = 1'b1;
        end
      end
      ST_SEND: begin
        if (ready_in) begin
          w_accept = 1'b1;
          if (w_last)        w_state_nxt = ST_DONE;
          else if (GAP == 0) w_state_nxt = ST_SEND;
          else               w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GW'(GAP - 1)) w_state_nxt = ST_SEND;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_data  <= '0;
      r_sent  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_run_start) begin
        r_id   <= '0;
        r_data <= '0;
        r_sent <= '0;
      end else if (w_accept) begin
        r_id   <= r_id + 8'd1;
        r_data <= r_data + DW'(1);
        r_sent <= r_sent + 16'd1;
      end
      if (r_state == ST_GAP) r_gap <= r_gap + GW'(1);
      else                   r_gap <= '0;
    end
  end

  if (DEST_MODE == 1) begin : g_rr
    tpg_dest_sel #(
      .N    (N),
      .NA   (NA),
      .NODE (NODE)
    ) u_dest (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_accept),
      .i_reload  (w_run_start),
      .o_dest    (w_dest)
    );
  end else begin : g_fixed
    assign w_dest = NA'(DEST);
  end

  // Flit is built from the live counters; they only move on accept, so it holds during stalls.
  assign valid_out = (r_state == ST_SEND);
  assign data_out  = valid_out
                   ? WIDTH'(pack_flit(WIDTH, NA, 32'(NODE), 32'(w_dest), r_id, wide_flit_t'(r_data)))
                   : '0;
  assign done      = (r_state == ST_DONE);
  assign sent_cnt  = r_sent;

endmodule

// File: tb/tb_tpg_source.sv
// Self-checking bench for tpg_source: table-driven handshake vectors, hand sequences for
// gap/round-robin/reset, and a randomized ready stream against a packet-level reference model.
module tb_tpg_source;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 0, a_ready = 0, a_valid, a_done;
  logic [31:0] a_data;
  logic [15:0] a_sent;
  logic        b_start = 0, b_ready = 0, b_valid, b_done;
  logic [31:0] b_data;
  logic [15:0] b_sent;
  logic        c_start = 0, c_ready = 0, c_valid, c_done;
  logic [31:0] c_data;
  logic [15:0] c_sent;
  logic        d_start = 0, d_ready = 0, d_valid, d_done;
  logic [31:0] d_data;
  logic [15:0] d_sent;

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST_MODE(0), .DEST(15), .NUM_PKTS(4), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .data_out(a_data), .valid_out(a_valid),
    .ready_in(a_ready), .done(a_done), .sent_cnt(a_sent));

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST_MODE(0), .DEST(15), .NUM_PKTS(3), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .data_out(b_data), .valid_out(b_valid),
    .ready_in(b_ready), .done(b_done), .sent_cnt(b_sent));

  tpg_source #(.WIDTH(32), .N(4), .NODE(1), .DEST_MODE(1), .DEST(0), .NUM_PKTS(6), .GAP(0)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .data_out(c_data), .valid_out(c_valid),
    .ready_in(c_ready), .done(c_done), .sent_cnt(c_sent));

  tpg_source #(.WIDTH(32), .N(16), .NODE(3), .DEST_MODE(0), .DEST(15), .NUM_PKTS(260), .GAP(0)) dut_d (
    .clk(clk), .rst(rst), .start(d_start), .data_out(d_data), .valid_out(d_valid),
    .ready_in(d_ready), .done(d_done), .sent_cnt(d_sent));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned pw2(input int e);
    return 64'd1 << e;
  endfunction

  // Packet k of a run: src/dst addresses, id = k mod 256, data = k mod 2^DW.
  function automatic logic [31:0] model_flit(input int na, input int src, input int dst, input int k);
    int dw;
    longint unsigned v;
    dw = 32 - 2 * na - 8;
    v = longint'(src) * pw2(32 - na) + longint'(dst) * pw2(32 - 2 * na)
      + longint'(k % 256) * pw2(dw) + longint'(k) % pw2(dw);
    return v[31:0];
  endfunction

  function automatic int rr_dst(input int node, input int n, input int k);
    int order[$];
    for (int i = 1; i < n; i++) order.push_back((node + i) % n);
    return order[k % (n - 1)];
  endfunction

  typedef struct {
    bit start;
    bit ready;
    bit valid;
    int id;
    bit done;
    int sent;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    int   m_sent;
    bit   m_run;
    bit   m_done;
    int   cyc;

    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 0, 1};
    tbl[2]  = '{0, 0, 1, 1, 0, 1};
    tbl[3]  = '{0, 0, 1, 1, 0, 1};
    tbl[4]  = '{0, 0, 1, 1, 0, 1};
    tbl[5]  = '{0, 1, 1, 2, 0, 2};
    tbl[6]  = '{0, 1, 1, 3, 0, 3};
    tbl[7]  = '{0, 1, 0, 0, 1, 4};
    tbl[8]  = '{0, 1, 0, 0, 1, 4};
    tbl[9]  = '{1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 0, 1};
    tbl[11] = '{0, 1, 1, 2, 0, 2};
    tbl[12] = '{0, 1, 1, 3, 0, 3};
    tbl[13] = '{0, 1, 0, 0, 1, 4};

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", a_valid, 0);
    chk("rst_data",  a_data,  0);
    chk("rst_done",  a_done,  0);
    chk("rst_sent",  a_sent,  0);
    chk("rst_d_valid", d_valid, 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", a_valid, 0);

    // stall, back-to-back and restart-from-done vectors
    for (int i = 0; i < 14; i++) begin
      a_start = tbl[i].start;
      a_ready = tbl[i].ready;
      tick();
      a_start = 1'b0;
      chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_done", i),  a_done,  tbl[i].done);
      chk($sformatf("tbl%0d_sent", i),  a_sent,  tbl[i].sent);
      if (tbl[i].valid)
        chk($sformatf("tbl%0d_data", i), a_data, model_flit(4, 3, 15, tbl[i].id));
    end

    // GAP=2: valid pattern 1,0,0 repeating, accepts three cycles apart
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit ev;
      ev = (i % 3 == 0) && (i / 3 < 3);
      chk($sformatf("gap%0d_valid", i), b_valid, ev);
      chk($sformatf("gap%0d_done", i),  b_done,  i >= 7);
      if (ev) chk($sformatf("gap%0d_data", i), b_data, model_flit(4, 3, 15, i / 3));
      tick();
    end
    chk("gap_sent", b_sent, 3);

    // round-robin destinations over N=4 skipping NODE=1
    c_ready = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] f_dst;
      logic [1:0] f_src;
      f_dst = c_data[29:28];
      f_src = c_data[31:30];
      chk($sformatf("rr%0d_valid", i), c_valid, 1);
      chk($sformatf("rr%0d_dst", i), f_dst, rr_dst(1, 4, i));
      chk($sformatf("rr%0d_src", i), f_src, 1);
      chk($sformatf("rr%0d_flit", i), c_data, model_flit(2, 1, rr_dst(1, 4, i), i));
      tick();
    end
    chk("rr_done", c_done, 1);
    chk("rr_sent", c_sent, 6);

    // reset aborts a run mid-stream; next start resends from id 0
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("abort_pre_sent", a_sent, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", a_valid, 0);
    chk("abort_sent",  a_sent,  0);
    chk("abort_data",  a_data,  0);
    chk("abort_done",  a_done,  0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("restart_valid", a_valid, 1);
    chk("restart_sent",  a_sent,  0);
    chk("restart_data",  a_data,  model_flit(4, 3, 15, 0));

    // randomized ready over two 260-packet runs, id wrap at 256
    m_sent = 0;
    m_run  = 0;
    m_done = 0;
    for (int run = 0; run < 2; run++) begin
      d_start = 1'b1;
      d_ready = ($urandom_range(0, 1) == 1);
      tick();
      d_start = 1'b0;
      m_run  = 1;
      m_done = 0;
      m_sent = 0;
      cyc    = 0;
      chk("rnd_first_valid", d_valid, 1);
      chk("rnd_first_data",  d_data,  model_flit(4, 3, 15, 0));
      while (m_run && cyc < 2000) begin
        d_ready = ($urandom_range(0, 3) != 0);
        d_start = ($urandom_range(0, 31) == 0);
        if (d_ready) begin
          m_sent++;
          if (m_sent == 260) begin
            m_run  = 0;
            m_done = 1;
          end
        end
        tick();
        d_start = 1'b0;
        cyc++;
        chk("rnd_valid", d_valid, m_run);
        chk("rnd_done",  d_done,  m_done);
        chk("rnd_sent",  d_sent,  m_sent);
        if (m_run) chk("rnd_data", d_data, model_flit(4, 3, 15, m_sent));
        if (m_run && m_sent == 256) begin
          chk("wrap_id",   d_data[23:16], 0);
          chk("wrap_data", d_data[15:0],  256);
        end
      end
      chk("rnd_run_done", d_done, 1);
      d_ready = 1'b0;
      tick();
      chk("rnd_done_sticky", d_done, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
